// File: rtl/sdram_arbiter.sv
// sdram_arbiter: grants the SDRAM command/data bus to one of the init,
// auto-refresh, write and read masters at a time.
// Fixed priority is refresh > write > read.
// Optional feature macro SDRAM_ARB_RR_EN: when write and read both request
// without a refresh pending, they alternate using a last-served flag.
module sdram_arbiter #(
  parameter int DQ_W   = 16,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  // initialisation master
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [1:0]        init_bank,
  input  logic [ADDR_W-1:0] init_addr,
  // auto-refresh master
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [1:0]        aref_bank,
  input  logic [ADDR_W-1:0] aref_addr,
  output logic              aref_en,
  // write master
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [1:0]        wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DQ_W-1:0]   wr_sdram_data,
  output logic              wr_en,
  // read master
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [1:0]        rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  // SDRAM pins
  output logic              sdram_cke,
  output logic [3:0]        sdram_cmd,
  output logic [1:0]        sdram_bank,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DQ_W-1:0]   sdram_dq_o,
  output logic              sdram_dq_oe
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ARBIT,
    ST_AREF,
    ST_WRITE,
    ST_READ
  } state_t;

  localparam logic [3:0] CMD_NOP = 4'b0111;

  state_t state;
  state_t state_nxt;

`ifdef SDRAM_ARB_RR_EN
  // 1 = write was the last transfer granted, 0 = read (reset: read, so write wins first)
  logic last_wr;

  // Remember which of write/read was granted most recently, updated on grant entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_wr <= 1'b0;
    end else if (state == ST_ARBIT && state_nxt == ST_WRITE) begin
      last_wr <= 1'b1;
    end else if (state == ST_ARBIT && state_nxt == ST_READ) begin
      last_wr <= 1'b0;
    end
  end
`endif

  // State register; reset aborts any running grant immediately
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: leave INIT once, arbitrate in ARBIT, return on the owner's *_end
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      ST_INIT: begin
        if (init_end) state_nxt = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (aref_req) begin
          state_nxt = ST_AREF;
        end else if (wr_req && rd_req) begin
`ifdef SDRAM_ARB_RR_EN
          state_nxt = last_wr ? ST_READ : ST_WRITE;
`else
          state_nxt = ST_WRITE;
`endif
        end else if (wr_req) begin
          state_nxt = ST_WRITE;
        end else if (rd_req) begin
          state_nxt = ST_READ;
        end
      end
      ST_AREF: begin
        if (aref_end) state_nxt = ST_ARBIT;
      end
      ST_WRITE: begin
        if (wr_end) state_nxt = ST_ARBIT;
      end
      ST_READ: begin
        if (rd_end) state_nxt = ST_ARBIT;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // Command/data mux: the bus follows whichever master owns the current state
  always_comb begin
    sdram_cmd   = CMD_NOP;
    sdram_bank  = 2'b00;
    sdram_addr  = '0;
    sdram_dq_o  = '0;
    sdram_dq_oe = 1'b0;
    case (state)
      ST_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_bank = init_bank;
        sdram_addr = init_addr;
      end
      ST_AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_bank = aref_bank;
        sdram_addr = aref_addr;
      end
      ST_WRITE: begin
        sdram_cmd   = wr_cmd;
        sdram_bank  = wr_bank;
        sdram_addr  = wr_addr;
        sdram_dq_o  = wr_sdram_data;
        sdram_dq_oe = wr_sdram_en;
      end
      ST_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_bank = rd_bank;
        sdram_addr = rd_addr;
      end
      default: begin
        sdram_cmd = CMD_NOP;
      end
    endcase
  end

  assign aref_en   = (state == ST_AREF);
  assign wr_en     = (state == ST_WRITE);
  assign rd_en     = (state == ST_READ);
  assign sdram_cke = 1'b1;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus a randomized
// phase, all compared every cycle against a bus-ownership model.
module tb_sdram_arbiter;

  localparam int DQ_W   = 16;
  localparam int ADDR_W = 13;

`ifdef SDRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              init_end;
  logic [3:0]        init_cmd;
  logic [1:0]        init_bank;
  logic [ADDR_W-1:0] init_addr;
  logic              aref_req, aref_end;
  logic [3:0]        aref_cmd;
  logic [1:0]        aref_bank;
  logic [ADDR_W-1:0] aref_addr;
  logic              aref_en;
  logic              wr_req, wr_end;
  logic [3:0]        wr_cmd;
  logic [1:0]        wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_sdram_en;
  logic [DQ_W-1:0]   wr_sdram_data;
  logic              wr_en;
  logic              rd_req, rd_end;
  logic [3:0]        rd_cmd;
  logic [1:0]        rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic              sdram_cke;
  logic [3:0]        sdram_cmd;
  logic [1:0]        sdram_bank;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DQ_W-1:0]   sdram_dq_o;
  logic              sdram_dq_oe;

  sdram_arbiter #(.DQ_W(DQ_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .init_end(init_end), .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_bank(aref_bank),
    .aref_addr(aref_addr), .aref_en(aref_en),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data), .wr_en(wr_en),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd), .sdram_bank(sdram_bank),
    .sdram_addr(sdram_addr), .sdram_dq_o(sdram_dq_o), .sdram_dq_oe(sdram_dq_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bus-ownership model: who holds the bus, whether init has finished,
  // and which of write/read was served last.
  localparam int OWN_NONE = 0;
  localparam int OWN_AREF = 1;
  localparam int OWN_WR   = 2;
  localparam int OWN_RD   = 3;

  bit m_ready;
  int m_owner;
  bit m_last_wr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ready   = 1'b0;
    m_owner   = OWN_NONE;
    m_last_wr = 1'b0;
  endtask

  // Apply one clock edge worth of rules using the inputs present at that edge
  task automatic model_update();
    if (!rst_n) begin
      model_reset();
    end else if (!m_ready) begin
      if (init_end) m_ready = 1'b1;
    end else if (m_owner == OWN_NONE) begin
      if (aref_req) m_owner = OWN_AREF;
      else if (wr_req && rd_req) m_owner = (RR && m_last_wr) ? OWN_RD : OWN_WR;
      else if (wr_req) m_owner = OWN_WR;
      else if (rd_req) m_owner = OWN_RD;
      if (m_owner == OWN_WR) m_last_wr = 1'b1;
      if (m_owner == OWN_RD) m_last_wr = 1'b0;
    end else begin
      if ((m_owner == OWN_AREF && aref_end) || (m_owner == OWN_WR && wr_end) ||
          (m_owner == OWN_RD && rd_end))
        m_owner = OWN_NONE;
    end
  endtask

  // Compare every DUT output with what the model says the bus should carry
  task automatic check_all();
    logic [3:0]        e_cmd;
    logic [1:0]        e_bank;
    logic [ADDR_W-1:0] e_addr;
    logic              e_oe;
    logic [DQ_W-1:0]   e_dq;
    e_cmd = 4'b0111; e_bank = 2'b00; e_addr = '0; e_oe = 1'b0; e_dq = '0;
    if (!m_ready) begin
      e_cmd = init_cmd; e_bank = init_bank; e_addr = init_addr;
    end else if (m_owner == OWN_AREF) begin
      e_cmd = aref_cmd; e_bank = aref_bank; e_addr = aref_addr;
    end else if (m_owner == OWN_WR) begin
      e_cmd = wr_cmd; e_bank = wr_bank; e_addr = wr_addr;
      e_oe = wr_sdram_en; e_dq = wr_sdram_data;
    end else if (m_owner == OWN_RD) begin
      e_cmd = rd_cmd; e_bank = rd_bank; e_addr = rd_addr;
    end
    check("aref_en", aref_en, m_ready && m_owner == OWN_AREF);
    check("wr_en", wr_en, m_ready && m_owner == OWN_WR);
    check("rd_en", rd_en, m_ready && m_owner == OWN_RD);
    check("sdram_cmd", sdram_cmd, e_cmd);
    check("sdram_bank", sdram_bank, e_bank);
    check("sdram_addr", sdram_addr, e_addr);
    check("sdram_dq_oe", sdram_dq_oe, e_oe);
    check("sdram_dq_o", sdram_dq_o, e_dq);
    check("sdram_cke", sdram_cke, 1'b1);
  endtask

  task automatic randomize_buses();
    init_cmd  = 4'($urandom); init_bank = 2'($urandom); init_addr = ADDR_W'($urandom);
    aref_cmd  = 4'($urandom); aref_bank = 2'($urandom); aref_addr = ADDR_W'($urandom);
    wr_cmd    = 4'($urandom); wr_bank   = 2'($urandom); wr_addr   = ADDR_W'($urandom);
    rd_cmd    = 4'($urandom); rd_bank   = 2'($urandom); rd_addr   = ADDR_W'($urandom);
  endtask

  // One clock: edge, model step, settle, compare, then fresh command buses
  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    check_all();
    randomize_buses();
  endtask

  // Wait (bounded) for any grant; who = 1 write, 2 read, 3 refresh, 0 timeout
  task automatic wait_grant(output int who);
    who = 0;
    for (int i = 0; i < 8 && who == 0; i++) begin
      cycle();
      if (wr_en) who = 1;
      else if (rd_en) who = 2;
      else if (aref_en) who = 3;
    end
    if (who == 0) check("grant_timeout", 32'd0, 32'd1);
  endtask

  int wr_cycles;
  int who;
  int exp_who;

  initial begin
    rst_n = 1'b0;
    init_end = 1'b0;
    aref_req = 1'b0; aref_end = 1'b0;
    wr_req = 1'b0; wr_end = 1'b0; wr_sdram_en = 1'b0; wr_sdram_data = '0;
    rd_req = 1'b0; rd_end = 1'b0;
    randomize_buses();
    model_reset();

    // Reset state
    #3;
    check_all();
    repeat (2) cycle();
    rst_n = 1'b1;

    // init_end sampled at the 20th edge after release -> ARBIT, NOP on the bus
    repeat (19) cycle();
    init_end = 1'b1;
    cycle();
    init_end = 1'b0;
    check("nop_after_init", sdram_cmd, 4'b0111);
    repeat (3) cycle();

    // Write burst: grant lasts 15 cycles with wr_end sampled 15 edges after rise
    wr_req = 1'b1;
    cycle();
    check("wr_grant_latency", wr_en, 1'b1);
    wr_req = 1'b0;
    wr_cycles = 1;
    for (int k = 0; k < 15; k++) begin
      wr_sdram_data = DQ_W'(k);
      wr_sdram_en   = k[0];
      wr_end        = (k == 14);
      cycle();
      if (wr_en) wr_cycles++;
    end
    wr_end = 1'b0; wr_sdram_en = 1'b0;
    check("wr_en_cycles", wr_cycles, 15);
    cycle();

    // Refresh beats write raised in the same cycle; write follows 2 cycles after aref_end
    aref_req = 1'b1; wr_req = 1'b1;
    cycle();
    check("aref_first", aref_en, 1'b1);
    aref_req = 1'b0;
    repeat (3) cycle();
    aref_end = 1'b1;
    cycle();
    aref_end = 1'b0;
    check("wr_not_yet", wr_en, 1'b0);
    cycle();
    check("wr_after_aref", wr_en, 1'b1);
    wr_req = 1'b0;

    // rd_end / aref_end during WRITE are ignored
    rd_end = 1'b1; aref_end = 1'b1; wr_sdram_en = 1'b1;
    cycle();
    rd_end = 1'b0; aref_end = 1'b0;
    cycle();
    check("wr_holds", wr_en, 1'b1);
    wr_end = 1'b1;
    cycle();
    wr_end = 1'b0; wr_sdram_en = 1'b0;
    cycle();

    // Both write and read held: fixed priority or alternation
    wr_req = 1'b1; rd_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_grant(who);
      exp_who = (RR && g[0]) ? 2 : 1;
      check("both_req_order", who, exp_who);
      cycle();
      if (who == 1) wr_end = 1'b1;
      else rd_end = 1'b1;
      cycle();
      wr_end = 1'b0; rd_end = 1'b0;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (2) cycle();

    // Asynchronous reset during WRITE
    wr_req = 1'b1; wr_sdram_en = 1'b1;
    cycle();
    check("wr_before_reset", wr_en, 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("reset_kills_wr", wr_en, 1'b0);
    check("reset_kills_oe", sdram_dq_oe, 1'b0);
    repeat (2) cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("no_grant_before_init", wr_en, 1'b0);
    end
    init_end = 1'b1;
    cycle();
    init_end = 1'b0;
    cycle();
    check("wr_after_reinit", wr_en, 1'b1);
    wr_req = 1'b0; wr_sdram_en = 1'b0;
    wr_end = 1'b1;
    cycle();
    wr_end = 1'b0;
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      aref_req      = ($urandom_range(0, 5) == 0);
      wr_req        = $urandom_range(0, 1) == 1;
      rd_req        = $urandom_range(0, 1) == 1;
      aref_end      = ($urandom_range(0, 3) == 0);
      wr_end        = ($urandom_range(0, 3) == 0);
      rd_end        = ($urandom_range(0, 3) == 0);
      init_end      = $urandom_range(0, 1) == 1;
      wr_sdram_en   = $urandom_range(0, 1) == 1;
      wr_sdram_data = DQ_W'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter: DQ_W, 16, SDRAM data width.
REQ-002 Parameter: ADDR_W, 13, SDRAM row/column address width.
REQ-003 clk  in  1  controller clock. rst_n  in  1  reset, asynchronous, active-low.
REQ-004 init_end  in  1  initialisation complete; init_cmd  in  4  command {cs_n,ras_n,cas_n,we_n}; init_bank  in  2  bank; init_addr  in  ADDR_W  address.
REQ-005 aref_req  in  1  refresh request; aref_end  in  1  refresh done; aref_cmd/aref_bank/aref_addr  in  4/2/ADDR_W  refresh command bus; aref_en  out  1  refresh grant.
REQ-006 wr_req  in  1  write request; wr_end  in  1  write done; wr_cmd/wr_bank/wr_addr  in  4/2/ADDR_W  write command bus; wr_sdram_en  in  1  write drives DQ; wr_sdram_data  in  DQ_W  write data; wr_en  out  1  write grant.
REQ-007 rd_req  in  1  read request; rd_end  in  1  read done; rd_cmd/rd_bank/rd_addr  in  4/2/ADDR_W  read command bus; rd_en  out  1  read grant.
REQ-008 sdram_cke  out  1; sdram_cmd  out  4; sdram_bank  out  2; sdram_addr  out  ADDR_W; sdram_dq_o  out  DQ_W; sdram_dq_oe  out  1  (DQ tristate enable).

Function
REQ-009 FSM states: INIT, ARBIT, AREF, WRITE, READ; state register updates on posedge clk.
REQ-010 INIT -> ARBIT on the cycle after init_end sampled high; INIT is left permanently until reset; later init_end values are ignored.
REQ-011 ARBIT priority: aref_req > wr_req > rd_req; chosen state entered next cycle; no request -> remain ARBIT.
REQ-012 AREF/WRITE/READ -> ARBIT on the cycle after the matching *_end sampled high; *_end from a non-granted master is ignored.
REQ-013 aref_en = (state==AREF), wr_en = (state==WRITE), rd_en = (state==READ); at most one grant high in any cycle.
REQ-014 Request-to-grant latency: request high in ARBIT at edge N -> grant high from edge N+1; at least one ARBIT cycle between consecutive grants.
REQ-015 Command mux (combinational from state): INIT -> init_*, AREF -> aref_*, WRITE -> wr_*, READ -> rd_*, ARBIT -> cmd 4'b0111 (NOP), bank 2'b00, addr 0.
REQ-016 sdram_dq_oe = wr_sdram_en when state==WRITE, else 0; sdram_dq_o = wr_sdram_data when state==WRITE, else 0.
REQ-017 sdram_cke is constant 1 after reset release.
REQ-018 Requests are level-sensitive; requests arriving outside ARBIT are not latched and must be held by the requester; pre-emption of a running grant never occurs.
REQ-019 aref_req raised during WRITE/READ is served in the first ARBIT cycle after that transfer ends, ahead of pending wr_req/rd_req.

Reset
REQ-020 rst_n low: state=INIT, aref_en=wr_en=rd_en=0, sdram_dq_oe=0, sdram_dq_o=0, sdram_cke=1, sdram_cmd/bank/addr follow init_*.
REQ-021 Reset mid-transfer aborts the grant immediately (asynchronous) and re-requires init_end before any further grant.

Configuration
REQ-022 Macro SDRAM_ARB_RR_EN defined: when wr_req and rd_req are both high in ARBIT without aref_req, grant alternates via a last-served flag (reset value = read, so write wins first); flag updates on entry to WRITE or READ.
REQ-023 SDRAM_ARB_RR_EN undefined: fixed priority write > read; no last-served flag present.

Verification
REQ-024 Reset release, init_end high at cycle 20 -> state ARBIT at 21, sdram_cmd=4'b0111 while no requests.
REQ-025 wr_req held, wr_end pulsed 14 cycles after wr_en rises -> wr_en high exactly 15 cycles, sdram_dq_oe mirrors wr_sdram_en, sdram_dq_o=wr_sdram_data (e.g. 0..9) only during WRITE.
REQ-026 aref_req and wr_req raised same cycle in ARBIT -> aref_en first; wr_en rises 2 cycles after aref_end sampled.
REQ-027 wr_req and rd_req held continuously -> without SDRAM_ARB_RR_EN only writes granted; with it grants alternate W,R,W,R.
REQ-028 rst_n pulsed low during WRITE -> wr_en and sdram_dq_oe 0 immediately; no grant until init_end re-observed.
REQ-029 rd_end/aref_end pulsed during WRITE -> ignored, wr_en stays high until wr_end.
